// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl : load/store controller between the execute stage and the
// data-memory bus. Accepts one load or store per handshake, issues a single
// word-aligned bus request with byte enables, waits for the bus response and
// returns an extended load result (or a store ack) together with an error flag.
//
// Parameters
//   TIMEOUT        cycles waited for bus_resp_valid before aborting (>= 1)
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   req_valid      in   CPU request present
//   req_ready      out  high only while idle
//   MemRd, MemWr   in   load / store select (exactly one must be set)
//   MemOp          in   000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
//   addr, wdata    in   byte address, right-aligned store data
//   resp_valid     out  one-cycle completion pulse
//   rdata, err     out  load result / error flag, non-zero only with resp_valid
//   bus_req_*      out  bus request channel (addr, wen, wdata, wmask)
//   bus_req_ready  in   bus accepts request
//   bus_resp_valid in   read data valid / write ack
//   bus_rdata      in   aligned read word
//   dbg_state      out  current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 RESP)
//
// Handshake: a transfer happens on a rising edge where valid && ready; once
// bus_req_valid rises it stays high with all bus_* fields frozen until
// bus_req_ready is seen.
// -----------------------------------------------------------------------------
module lsu_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic [2:0]  MemOp,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        err,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [31:0] bus_addr,
    output logic        bus_wen,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wmask,
    input  logic        bus_resp_valid,
    input  logic [31:0] bus_rdata,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam int             CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [31:0]    r_addr;
    logic [31:0]    r_wdata;
    logic [2:0]     r_op;
    logic           r_wr;
    logic [31:0]    r_rdata;
    logic           r_err;
    logic [CW-1:0]  r_cnt;

    logic [CW-1:0]  w_cnt_nxt;
    logic [31:0]    w_rdata_nxt;
    logic           w_err_nxt;
    logic           w_illegal;
    logic           w_accept;
    logic           w_in_req;
    logic [1:0]     w_off;
    logic [31:0]    w_lane_data;
    logic [3:0]     w_lane_mask;
    logic [31:0]    w_rshift;
    logic [31:0]    w_load;

    // -------------------------------------------------------------------------
    // Request legality, evaluated on the live inputs at acceptance.
    // -------------------------------------------------------------------------
    always_comb begin
        w_illegal = 1'b0;
        if (MemRd == MemWr)
            w_illegal = 1'b1;
        case (MemOp)
            3'b000, 3'b100: ;
            3'b001, 3'b101: if (addr[1:0] == 2'b11) w_illegal = 1'b1;
            3'b010:         if (addr[1:0] != 2'b00) w_illegal = 1'b1;
            default:        w_illegal = 1'b1;
        endcase
        // Unsigned variants are meaningless for stores.
        if (MemWr && MemOp[2])
            w_illegal = 1'b1;
    end

    assign w_accept = (r_state == S_IDLE) && req_valid;
    assign w_in_req = (r_state == S_REQ);
    assign w_off    = r_addr[1:0];

    // -------------------------------------------------------------------------
    // Store lane placement from the latched request. Only legal stores
    // (op 000/001/010) ever reach REQ, so op[1:0] selects the width.
    // -------------------------------------------------------------------------
    always_comb begin
        w_lane_data = '0;
        w_lane_mask = '0;
        case (r_op[1:0])
            2'b00: begin
                w_lane_data = {24'b0, r_wdata[7:0]} << {w_off, 3'b000};
                w_lane_mask = 4'b0001 << w_off;
            end
            2'b01: begin
                w_lane_data = {16'b0, r_wdata[15:0]} << {w_off, 3'b000};
                w_lane_mask = 4'b0011 << w_off;
            end
            default: begin
                w_lane_data = r_wdata;
                w_lane_mask = 4'b1111;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Load extraction: shift the addressed lane down to bit 0, then extend.
    // -------------------------------------------------------------------------
    assign w_rshift = bus_rdata >> {w_off, 3'b000};

    always_comb begin
        w_load = '0;
        case (r_op)
            3'b000:  w_load = {{24{w_rshift[7]}},  w_rshift[7:0]};
            3'b100:  w_load = {24'b0,              w_rshift[7:0]};
            3'b001:  w_load = {{16{w_rshift[15]}}, w_rshift[15:0]};
            3'b101:  w_load = {16'b0,              w_rshift[15:0]};
            default: w_load = bus_rdata;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM next state. rdata/err next values default to 0 so the registered
    // outputs are non-zero only during the single RESP cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rdata_nxt = '0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_illegal) begin
                        w_state_nxt = S_RESP;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (bus_req_ready) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            S_WAIT: begin
                // A response in the final waiting cycle still wins over timeout.
                if (bus_resp_valid) begin
                    w_state_nxt = S_RESP;
                    w_rdata_nxt = r_wr ? 32'h0 : w_load;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_RESP;
                    w_err_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rdata <= w_rdata_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_op    <= '0;
            r_wr    <= 1'b0;
        end else if (w_accept) begin
            r_addr  <= addr;
            r_wdata <= wdata;
            r_op    <= MemOp;
            r_wr    <= MemWr;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. Bus fields are forced to 0 outside REQ so the bus sees a quiet
    // channel; bus_req_valid is a pure state decode, so an asynchronous reset
    // drops it immediately.
    // -------------------------------------------------------------------------
    assign req_ready     = (r_state == S_IDLE);
    assign resp_valid    = (r_state == S_RESP);
    assign rdata         = r_rdata;
    assign err           = r_err;
    assign bus_req_valid = w_in_req;
    assign bus_addr      = w_in_req ? {r_addr[31:2], 2'b00} : 32'h0;
    assign bus_wen       = w_in_req & r_wr;
    assign bus_wdata     = (w_in_req && r_wr) ? w_lane_data : 32'h0;
    assign bus_wmask     = (w_in_req && r_wr) ? w_lane_mask : 4'h0;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for lsu_ctrl (TIMEOUT = 4). Expected {err, rdata} results are
// pushed to exp_q when a request is driven and popped when resp_valid fires.
// -----------------------------------------------------------------------------
module tb_lsu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        MemRd;
  logic        MemWr;
  logic [2:0]  MemOp;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        err;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [31:0] bus_addr;
  logic        bus_wen;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wmask;
  logic        bus_resp_valid;
  logic [31:0] bus_rdata;
  logic [1:0]  dbg_state;

  int n_run;
  int n_fail;
  int cyc;
  logic [32:0] exp_q[$];

  lsu_ctrl #(.TIMEOUT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .MemRd          (MemRd),
    .MemWr          (MemWr),
    .MemOp          (MemOp),
    .addr           (addr),
    .wdata          (wdata),
    .resp_valid     (resp_valid),
    .rdata          (rdata),
    .err            (err),
    .bus_req_valid  (bus_req_valid),
    .bus_req_ready  (bus_req_ready),
    .bus_addr       (bus_addr),
    .bus_wen        (bus_wen),
    .bus_wdata      (bus_wdata),
    .bus_wmask      (bus_wmask),
    .bus_resp_valid (bus_resp_valid),
    .bus_rdata      (bus_rdata),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [32:0] model_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] op);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[8*off +: 8];
    h = (off == 2'd3) ? 16'h0 : w[8*off +: 16];
    case (op)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0, h};
      default: r = w;
    endcase
    return {1'b0, r};
  endfunction

  // ---------------- driver tasks ----------------
  // Waits for req_ready, presents one request for the accepting edge and
  // returns 1ns after it (cycle 1 of the transaction).
  task automatic issue(input logic rd, input logic wr, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] wd);
    int k;
    k = 0;
    while (!req_ready && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    if (!req_ready) begin
      n_run++; n_fail++;
      $display("FAIL issue_wait_ready got req_ready=%0b exp 1", req_ready);
    end
    req_valid = 1'b1; MemRd = rd; MemWr = wr; MemOp = op; addr = a; wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; MemRd = 1'b0; MemWr = 1'b0; MemOp = 3'b0; addr = '0; wdata = '0;
  endtask

  // Acts as the bus responder: grants after rdy_dly stall cycles, answers one
  // cycle after the grant. Returns in the cycle resp_valid is seen, with lat
  // the cycle number relative to the accepting edge.
  task automatic serve(input int rdy_dly, input logic [31:0] word,
                       output int lat, output logic seen);
    logic hs;
    logic fire;
    int   d;
    hs = 1'b0; seen = 1'b0; lat = 1; d = rdy_dly;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (resp_valid) begin
        seen = 1'b1;
      end else begin
        bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
        if (hs) begin
          bus_resp_valid = 1'b1; bus_rdata = word;
        end else if (bus_req_valid) begin
          if (d == 0) bus_req_ready = 1'b1;
          else d--;
        end
        #1;
        fire = bus_req_valid && bus_req_ready;
        @(posedge clk); #1;
        hs = hs | fire;
        lat++;
      end
    end
    bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_rdata = '0;
    if (!seen) begin
      n_run++; n_fail++;
      $display("FAIL serve_timeout got no resp_valid exp pulse");
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_run++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready got %0b exp 1", req_ready); end
    n_run++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid got %0b exp 0", resp_valid); end
    n_run++; if (bus_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_bus_req_valid got %0b exp 0", bus_req_valid); end
    n_run++; if ({rdata, err} !== 33'h0) begin n_fail++; $display("FAIL rst_rdata_err got %h/%0b exp 0/0", rdata, err); end
    n_run++; if ({bus_addr, bus_wen, bus_wdata, bus_wmask} !== 69'h0) begin n_fail++; $display("FAIL rst_bus_fields got %h %0b %h %h exp 0", bus_addr, bus_wen, bus_wdata, bus_wmask); end
    n_run++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL rst_state got %0d exp 0", dbg_state); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_byte();
    int lat; logic seen; logic [32:0] e;
    exp_q.push_back({1'b0, 32'hFFFF_FF80});
    issue(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0);
    n_run++; if (bus_req_valid !== 1'b1) begin n_fail++; $display("FAIL lb_bus_req_valid got %0b exp 1", bus_req_valid); end
    n_run++; if (bus_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL lb_bus_addr got %h exp 80000000", bus_addr); end
    n_run++; if ({bus_wen, bus_wmask} !== 5'b0) begin n_fail++; $display("FAIL lb_wen_mask got %0b/%b exp 0/0000", bus_wen, bus_wmask); end
    serve(0, 32'h80FF_1234, lat, seen);
    n_run++; if (lat !== 3) begin n_fail++; $display("FAIL lb_latency got %0d exp 3", lat); end
    if (seen && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_run++; if ({err, rdata} !== e) begin n_fail++; $display("FAIL lb_result got %0b/%h exp %0b/%h", err, rdata, e[32], e[31:0]); end
    end
    @(posedge clk); #1;
    n_run++; if ({resp_valid, rdata} !== 33'h0) begin n_fail++; $display("FAIL lb_after_resp got %0b/%h exp 0/0", resp_valid, rdata); end
  endtask

  task automatic test_load_half();
    int lat; logic seen; logic [32:0] e;
    logic [2:0] ops [2];
    ops[0] = 3'b101; ops[1] = 3'b001;
    exp_q.push_back({1'b0, 32'h0000_BEEF});
    exp_q.push_back({1'b0, 32'hFFFF_BEEF});
    for (int i = 0; i < 2; i++) begin
      issue(1'b1, 1'b0, ops[i], 32'h8000_0002, 32'h0);
      serve(1, 32'hBEEF_1234, lat, seen);
      if (seen && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_run++; if ({err, rdata} !== e) begin n_fail++; $display("FAIL lh_result op=%b got %0b/%h exp %0b/%h", ops[i], err, rdata, e[32], e[31:0]); end
      end
    end
  endtask

  task automatic test_store_half();
    int lat; logic seen; logic [32:0] e;
    exp_q.push_back(33'h0);
    issue(1'b0, 1'b1, 3'b001, 32'h8000_0001, 32'h1234_ABCD);
    n_run++; if (bus_wdata !== 32'h00AB_CD00) begin n_fail++; $display("FAIL sh_wdata got %h exp 00abcd00", bus_wdata); end
    n_run++; if (bus_wmask !== 4'b0110) begin n_fail++; $display("FAIL sh_wmask got %b exp 0110", bus_wmask); end
    n_run++; if (bus_wen !== 1'b1) begin n_fail++; $display("FAIL sh_wen got %0b exp 1", bus_wen); end
    n_run++; if (bus_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL sh_addr got %h exp 80000000", bus_addr); end
    serve(0, 32'hDEAD_BEEF, lat, seen);
    if (seen && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_run++; if ({err, rdata} !== e) begin n_fail++; $display("FAIL sh_result got %0b/%h exp %0b/%h", err, rdata, e[32], e[31:0]); end
    end
    // Byte store into the top lane and a word store.
    issue(1'b0, 1'b1, 3'b000, 32'h0000_0013, 32'hFFFF_FF5A);
    n_run++; if ({bus_wdata, bus_wmask} !== {32'h5A00_0000, 4'b1000}) begin n_fail++; $display("FAIL sb_lane got %h/%b exp 5a000000/1000", bus_wdata, bus_wmask); end
    exp_q.push_back(33'h0);
    serve(0, 32'h0, lat, seen);
    if (seen && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_run++; if ({err, rdata} !== e) begin n_fail++; $display("FAIL sb_result got %0b/%h exp %0b/%h", err, rdata, e[32], e[31:0]); end
    end
  endtask

  task automatic test_illegal();
    int lat; logic seen; logic [32:0] e;
    // {rd, wr, op, addr}
    logic [36:0] tbl [6];
    tbl[0] = {1'b1, 1'b0, 3'b010, 32'h8000_0002};  // misaligned word load
    tbl[1] = {1'b0, 1'b1, 3'b100, 32'h8000_0000};  // unsigned store
    tbl[2] = {1'b1, 1'b1, 3'b000, 32'h8000_0000};  // both rd and wr
    tbl[3] = {1'b0, 1'b0, 3'b000, 32'h8000_0000};  // neither
    tbl[4] = {1'b1, 1'b0, 3'b011, 32'h8000_0000};  // reserved op
    tbl[5] = {1'b1, 1'b0, 3'b101, 32'h8000_0003};  // half at offset 3
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({1'b1, 32'h0});
      issue(tbl[i][36], tbl[i][35], tbl[i][34:32], tbl[i][31:0], 32'hFFFF_FFFF);
      n_run++; if ({bus_req_valid, resp_valid} !== 2'b01) begin n_fail++; $display("FAIL ill_c1_%0d got bus_req_valid=%0b resp_valid=%0b exp 0/1", i, bus_req_valid, resp_valid); end
      serve(0, 32'h0, lat, seen);
      if (seen && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_run++; if ({err, rdata} !== e) begin n_fail++; $display("FAIL ill_result_%0d got %0b/%h exp %0b/%h", i, err, rdata, e[32], e[31:0]); end
      end
    end
  endtask

  task automatic test_timeout();
    int n; logic [32:0] e; logic bad;
    exp_q.push_back({1'b1, 32'h0});
    issue(1'b0, 1'b1, 3'b000, 32'h8000_0002, 32'h0000_00A5);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus_req_ready = 1'b0;
      if ({bus_req_valid, bus_addr, bus_wen, bus_wdata, bus_wmask} !==
          {1'b1, 32'h8000_0000, 1'b1, 32'h00A5_0000, 4'b0100}) bad = 1'b1;
      @(posedge clk); #1;
    end
    n_run++; if (bad !== 1'b0 || bus_req_valid !== 1'b1) begin n_fail++; $display("FAIL to_fields_stable got %h/%h/%b exp 80000000/00a50000/0100", bus_addr, bus_wdata, bus_wmask); end
    bus_req_ready = 1'b1;
    @(posedge clk); #1;
    bus_req_ready = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    n_run++; if (n !== 4) begin n_fail++; $display("FAIL to_wait_cycles got %0d exp 4", n); end
    if (resp_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_run++; if ({err, rdata} !== e) begin n_fail++; $display("FAIL to_result got %0b/%h exp %0b/%h", err, rdata, e[32], e[31:0]); end
    end
    @(posedge clk); #1;
    bad = 1'b0;
    bus_resp_valid = 1'b1; bus_rdata = 32'h1111_2222;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) bad = 1'b1;
    end
    bus_resp_valid = 1'b0; bus_rdata = '0;
    n_run++; if (bad !== 1'b0) begin n_fail++; $display("FAIL to_stray_resp got resp_valid=%0b req_ready=%0b exp 0/1", resp_valid, req_ready); end
  endtask

  task automatic test_reset_mid();
    int lat; logic seen; logic [32:0] e; logic bad;
    issue(1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0);
    bus_req_ready = 1'b1;
    @(posedge clk); #1;
    bus_req_ready = 1'b0;
    n_run++; if (dbg_state !== 2'd2) begin n_fail++; $display("FAIL rm_in_wait got state %0d exp 2", dbg_state); end
    rst_n = 1'b0;
    #1;
    n_run++; if ({req_ready, bus_req_valid, resp_valid} !== 3'b100) begin n_fail++; $display("FAIL rm_async got req_ready=%0b bus_req_valid=%0b resp_valid=%0b exp 1/0/0", req_ready, bus_req_valid, resp_valid); end
    @(negedge clk); rst_n = 1'b1;
    bad = 1'b0;
    bus_resp_valid = 1'b1; bus_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b0) bad = 1'b1;
    end
    bus_resp_valid = 1'b0;
    n_run++; if (bad !== 1'b0) begin n_fail++; $display("FAIL rm_no_resp got resp_valid=1 exp 0"); end
    // Reset while the bus request is outstanding drops it without a clock.
    issue(1'b1, 1'b0, 3'b010, 32'h8000_0020, 32'h0);
    n_run++; if (bus_req_valid !== 1'b1) begin n_fail++; $display("FAIL rm_req_up got %0b exp 1", bus_req_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_run++; if (bus_req_valid !== 1'b0) begin n_fail++; $display("FAIL rm_req_drop got %0b exp 0", bus_req_valid); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back({1'b0, 32'h0000_007F});
    issue(1'b1, 1'b0, 3'b100, 32'h8000_0001, 32'h0);
    serve(0, 32'h0000_7F00, lat, seen);
    n_run++; if (lat !== 3) begin n_fail++; $display("FAIL rm_next_latency got %0d exp 3", lat); end
    if (seen && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_run++; if ({err, rdata} !== e) begin n_fail++; $display("FAIL rm_next_result got %0b/%h exp %0b/%h", err, rdata, e[32], e[31:0]); end
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic seen; logic [32:0] e;
    logic [2:0]  op;
    logic [1:0]  off;
    logic [31:0] word;
    int prev_cyc;
    int sel;
    prev_cyc = -1;
    for (int i = 0; i < 10; i++) begin
      sel  = $urandom_range(0, 4);
      op   = (sel == 0) ? 3'b000 : (sel == 1) ? 3'b001 : (sel == 2) ? 3'b010 :
             (sel == 3) ? 3'b100 : 3'b101;
      off  = 2'($urandom_range(0, 3));
      if (op[1:0] == 2'b10) off = 2'd0;
      if (op[1:0] == 2'b01 && off == 2'd3) off = 2'd2;
      word = $urandom;
      exp_q.push_back(model_load(word, off, op));
      issue(1'b1, 1'b0, op, {28'h4000_000, 2'b00, off}, 32'h0);
      serve(0, word, lat, seen);
      if (seen && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_run++; if ({err, rdata} !== e) begin n_fail++; $display("FAIL b2b_result_%0d op=%b off=%0d got %0b/%h exp %0b/%h", i, op, off, err, rdata, e[32], e[31:0]); end
        if (prev_cyc >= 0) begin
          n_run++; if (cyc - prev_cyc !== 4) begin n_fail++; $display("FAIL b2b_gap_%0d got %0d exp 4", i, cyc - prev_cyc); end
        end
        prev_cyc = cyc;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_run = 0; n_fail = 0;
    rst_n = 1'b0; req_valid = 1'b0; MemRd = 1'b0; MemWr = 1'b0; MemOp = 3'b0;
    addr = '0; wdata = '0; bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_rdata = '0;
    test_reset();
    test_load_byte();
    test_load_half();
    test_store_half();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    n_run++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drain got %0d left exp 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
